// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state/owner types and counter width for mem_arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_IF,
    BUSY_LS
  } arb_state_t;

  typedef enum logic {
    OWN_IF,
    OWN_LS
  } arb_owner_t;

  localparam int STARVE_CNT_W = 4;

endpackage

// File: rtl/arb_starve_ctr.sv
// rtl/arb_starve_ctr.sv - saturating fetch-wait counter; flag raises once MAX_WAIT is reached
module arb_starve_ctr
  import mem_arb_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic waiting,
  input  logic grant,
  input  logic clear,
  output logic flag
);

  localparam logic [STARVE_CNT_W-1:0] CNT_MAX = STARVE_CNT_W'(MAX_WAIT);

  logic [STARVE_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (grant || clear) begin
      cnt_d = '0;
    end else if (waiting && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + STARVE_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign flag = (cnt_q == CNT_MAX);

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-outstanding IF/LS memory port arbiter; MEM_ARBITER_PERF_EN adds grant/stall counters
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req_valid,
  output logic                if_req_ready,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_rsp_valid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                ls_req_valid,
  output logic                ls_req_ready,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic                ls_we,
  input  logic [DATA_W/8-1:0] ls_wstrb,
  input  logic [DATA_W-1:0]   ls_wdata,
  output logic                ls_rsp_valid,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rdata
`ifdef MEM_ARBITER_PERF_EN
  ,
  output logic [31:0]         perf_if_grants,
  output logic [31:0]         perf_ls_grants,
  output logic [31:0]         perf_if_stall
`endif
);

  arb_state_t state_q, state_d;
  arb_owner_t win_owner;
  logic       win_valid;
  logic       starve_flag;
  logic       if_hs, ls_hs;

  always_comb begin
    win_valid = 1'b0;
    win_owner = OWN_LS;
    if (state_q == IDLE) begin
      if (starve_flag && if_req_valid) begin
        win_valid = 1'b1;
        win_owner = OWN_IF;
      end else if (ls_req_valid) begin
        win_valid = 1'b1;
        win_owner = OWN_LS;
      end else if (if_req_valid) begin
        win_valid = 1'b1;
        win_owner = OWN_IF;
      end
    end
  end

  // Gating with reset keeps a held request from leaking to memory while reset is low.
  always_comb begin
    mem_req_valid = 1'b0;
    mem_addr      = '0;
    mem_we        = 1'b0;
    mem_wstrb     = '0;
    mem_wdata     = '0;
    if_req_ready  = 1'b0;
    ls_req_ready  = 1'b0;
    if (reset && win_valid) begin
      mem_req_valid = 1'b1;
      if (win_owner == OWN_LS) begin
        mem_addr     = ls_addr;
        mem_we       = ls_we;
        mem_wstrb    = ls_wstrb;
        mem_wdata    = ls_wdata;
        ls_req_ready = mem_req_ready;
      end else begin
        mem_addr     = if_addr;
        if_req_ready = mem_req_ready;
      end
    end
  end

  assign if_hs = if_req_valid && if_req_ready;
  assign ls_hs = ls_req_valid && ls_req_ready;

  always_comb begin
    state_d      = state_q;
    if_rsp_valid = 1'b0;
    ls_rsp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (if_hs) begin
          state_d = BUSY_IF;
        end else if (ls_hs) begin
          state_d = BUSY_LS;
        end
      end
      BUSY_IF: begin
        if (mem_rsp_valid) begin
          if_rsp_valid = 1'b1;
          state_d      = IDLE;
        end
      end
      BUSY_LS: begin
        if (mem_rsp_valid) begin
          ls_rsp_valid = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign if_rdata = mem_rdata;
  assign ls_rdata = mem_rdata;

  arb_starve_ctr #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve (
    .clk     (clk),
    .reset   (reset),
    .waiting (if_req_valid && !if_hs),
    .grant   (if_hs),
    .clear   ((state_q == IDLE) && !if_req_valid),
    .flag    (starve_flag)
  );

`ifdef MEM_ARBITER_PERF_EN
  logic [31:0] perf_if_grants_q, perf_ls_grants_q, perf_if_stall_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_if_grants_q <= '0;
      perf_ls_grants_q <= '0;
      perf_if_stall_q  <= '0;
    end else begin
      if (if_hs) perf_if_grants_q <= perf_if_grants_q + 32'd1;
      if (ls_hs) perf_ls_grants_q <= perf_ls_grants_q + 32'd1;
      if (if_req_valid && !if_req_ready) perf_if_stall_q <= perf_if_stall_q + 32'd1;
    end
  end

  assign perf_if_grants = perf_if_grants_q;
  assign perf_ls_grants = perf_ls_grants_q;
  assign perf_if_stall  = perf_if_stall_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized and directed bench for mem_arbiter against a policy-level reference model
module tb_mem_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SW   = DW / 8;
  localparam int MAXW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req_valid, if_req_ready, if_rsp_valid;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          ls_req_valid, ls_req_ready, ls_we, ls_rsp_valid;
  logic [AW-1:0] ls_addr;
  logic [SW-1:0] ls_wstrb;
  logic [DW-1:0] ls_wdata, ls_rdata;
  logic          mem_req_valid, mem_req_ready, mem_we, mem_rsp_valid;
  logic [AW-1:0] mem_addr;
  logic [SW-1:0] mem_wstrb;
  logic [DW-1:0] mem_wdata, mem_rdata;
`ifdef MEM_ARBITER_PERF_EN
  logic [31:0]   perf_if_grants, perf_ls_grants, perf_if_stall;
`endif

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MAXW)) dut (
    .clk(clk), .reset(reset),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_rsp_valid(if_rsp_valid), .if_rdata(if_rdata),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_addr(ls_addr),
    .ls_we(ls_we), .ls_wstrb(ls_wstrb), .ls_wdata(ls_wdata),
    .ls_rsp_valid(ls_rsp_valid), .ls_rdata(ls_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata)
`ifdef MEM_ARBITER_PERF_EN
    , .perf_if_grants(perf_if_grants), .perf_ls_grants(perf_ls_grants), .perf_if_stall(perf_if_stall)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Memory contents: explicit writes override a fixed address hash.
  logic [31:0] mem_data [logic [31:0]];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_data.exists(a)) return mem_data[a];
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  typedef struct {
    bit          is_store;
    logic [31:0] data;
  } ls_exp_t;

  // Reference model: who owns memory (0 none, 1 IF, 2 LS) and how long IF has waited.
  int          m_owner = 0;
  int          m_wait  = 0;
  logic [31:0] q_if[$];
  ls_exp_t     q_ls[$];
  int          n_if_hs = 0, n_ls_hs = 0, n_if_stall = 0;

  // Memory-side and requester-side bench state.
  bit          mo = 1'b0;
  int          mo_rsp_cyc = 0;
  logic [31:0] mo_addr = '0;
  int          cyc = 0;
  int          lat_fix = 1;
  int          rdy_mode = 1;
  bit          stray_en = 1'b0;
  bit          rand_en = 1'b0;
  int          if_pct = 50, ls_pct = 50;
  bit          if_pend = 1'b0, ls_pend = 1'b0;

  logic        s_if_rdy, s_ls_rdy, s_mem_v, s_mem_we, s_if_rsp, s_ls_rsp;
  logic [3:0]  s_mem_wstrb;
  logic [31:0] s_mem_addr, s_if_rdata, s_ls_rdata;

  task automatic model_check();
    int          win;
    logic        e_ifr, e_lsr, e_mv, e_we, e_ifrsp, e_lsrsp;
    logic [3:0]  e_st;
    logic [31:0] e_addr, e_wd, e_data;
    ls_exp_t     le;
    s_if_rdy = if_req_ready;  s_ls_rdy = ls_req_ready;  s_mem_v = mem_req_valid;
    s_mem_we = mem_we;        s_mem_wstrb = mem_wstrb;  s_mem_addr = mem_addr;
    s_if_rsp = if_rsp_valid;  s_ls_rsp = ls_rsp_valid;
    s_if_rdata = if_rdata;    s_ls_rdata = ls_rdata;
    if (!reset) begin
      check_eq("rst_if_req_ready", if_req_ready, 0);
      check_eq("rst_ls_req_ready", ls_req_ready, 0);
      check_eq("rst_mem_req_valid", mem_req_valid, 0);
      check_eq("rst_mem_we", mem_we, 0);
      check_eq("rst_mem_wstrb", mem_wstrb, 0);
      check_eq("rst_if_rsp_valid", if_rsp_valid, 0);
      check_eq("rst_ls_rsp_valid", ls_rsp_valid, 0);
      m_owner = 0; m_wait = 0; q_if.delete(); q_ls.delete();
      n_if_hs = 0; n_ls_hs = 0; n_if_stall = 0;
    end else begin
      win = 0;
      if (m_owner == 0) begin
        if (if_req_valid && m_wait >= MAXW) win = 1;
        else if (ls_req_valid)              win = 2;
        else if (if_req_valid)              win = 1;
      end
      e_mv    = (win != 0);
      e_ifr   = (win == 1) && mem_req_ready;
      e_lsr   = (win == 2) && mem_req_ready;
      e_addr  = (win == 1) ? if_addr : ls_addr;
      e_we    = (win == 2) && ls_we;
      e_st    = (win == 2) ? ls_wstrb : 4'h0;
      e_wd    = (win == 2) ? ls_wdata : 32'h0;
      e_ifrsp = (m_owner == 1) && mem_rsp_valid;
      e_lsrsp = (m_owner == 2) && mem_rsp_valid;
      check_eq("mem_req_valid", mem_req_valid, e_mv);
      check_eq("if_req_ready", if_req_ready, e_ifr);
      check_eq("ls_req_ready", ls_req_ready, e_lsr);
      check_eq("if_rsp_valid", if_rsp_valid, e_ifrsp);
      check_eq("ls_rsp_valid", ls_rsp_valid, e_lsrsp);
      if (e_mv) begin
        check_eq("mem_addr", mem_addr, e_addr);
        check_eq("mem_we", mem_we, e_we);
        check_eq("mem_wstrb", mem_wstrb, e_st);
        check_eq("mem_wdata", mem_wdata, e_wd);
      end
      if (e_ifrsp) begin
        if (q_if.size() > 0) begin
          e_data = q_if.pop_front();
          check_eq("if_rdata", if_rdata, e_data);
        end else check_eq("if_queue_size", q_if.size(), 1);
      end
      if (e_lsrsp) begin
        if (q_ls.size() > 0) begin
          le = q_ls.pop_front();
          if (!le.is_store) check_eq("ls_rdata", ls_rdata, le.data);
        end else check_eq("ls_queue_size", q_ls.size(), 1);
      end
      if (e_ifr) begin q_if.push_back(mem_rd(if_addr)); n_if_hs++; end
      if (e_lsr) begin
        le.is_store = ls_we; le.data = mem_rd(ls_addr);
        q_ls.push_back(le); n_ls_hs++;
      end
      if (if_req_valid && !e_ifr) n_if_stall++;
      if (e_ifr)             m_wait = 0;
      else if (if_req_valid) m_wait = (m_wait + 1 > MAXW) ? MAXW : m_wait + 1;
      else if (m_owner == 0) m_wait = 0;
      if (m_owner == 0) m_owner = e_ifr ? 1 : (e_lsr ? 2 : 0);
      else if (mem_rsp_valid) m_owner = 0;
    end
    // Memory and requesters react to what the DUT actually did.
    if (mo && cyc == mo_rsp_cyc) mo = 1'b0;
    if (mem_req_valid && mem_req_ready) begin
      mo = 1'b1; mo_addr = mem_addr;
      mo_rsp_cyc = cyc + ((lat_fix != 0) ? lat_fix : int'($urandom_range(1, 3)));
      if (mem_we) begin
        e_data = mem_rd(mem_addr);
        for (int b = 0; b < 4; b++) if (mem_wstrb[b]) e_data[8*b +: 8] = mem_wdata[8*b +: 8];
        mem_data[mem_addr] = e_data;
      end
    end
    if (if_req_valid && if_req_ready) if_pend = 1'b0;
    if (ls_req_valid && ls_req_ready) ls_pend = 1'b0;
  endtask

  task automatic step();
    mem_rsp_valid = 1'b0;
    mem_rdata     = $urandom;
    if (mo && cyc == mo_rsp_cyc) begin
      mem_rsp_valid = 1'b1;
      mem_rdata     = mem_rd(mo_addr);
    end else if (!mo && stray_en && $urandom_range(0, 15) == 0) begin
      mem_rsp_valid = 1'b1;
    end
    case (rdy_mode)
      0:       mem_req_ready = !mo && ($urandom_range(0, 3) != 0);
      1:       mem_req_ready = !mo;
      default: mem_req_ready = 1'b0;
    endcase
    if (rand_en) begin
      if (!if_pend && $urandom_range(0, 99) < if_pct) begin
        if_pend = 1'b1;
        if_addr = 32'($urandom_range(0, 63)) << 2;
      end
      if (!ls_pend && $urandom_range(0, 99) < ls_pct) begin
        ls_pend  = 1'b1;
        ls_addr  = 32'($urandom_range(0, 63)) << 2;
        ls_we    = 1'($urandom_range(0, 1));
        ls_wstrb = 4'($urandom_range(1, 15));
        ls_wdata = $urandom;
      end
    end
    if_req_valid = if_pend;
    ls_req_valid = ls_pend;
    @(negedge clk);
    model_check();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic ls_set(input logic [31:0] a, input logic we, input logic [3:0] st, input logic [31:0] d);
    ls_pend = 1'b1; ls_addr = a; ls_we = we; ls_wstrb = st; ls_wdata = d;
  endtask

  int  n_idle;
  bit  got, saw_ls;

  initial begin
    reset = 1'b0;
    if_req_valid = 0; if_addr = '0; ls_req_valid = 0; ls_addr = '0; ls_we = 0;
    ls_wstrb = '0; ls_wdata = '0; mem_req_ready = 0; mem_rsp_valid = 0; mem_rdata = '0;
    mem_data[32'h8] = 32'h00A0_0093;
    if_pend = 1'b1; if_addr = 32'h40;
    repeat (3) step();
    reset = 1'b1;
    if_pend = 1'b0;
    step();

    // IF-only read with latency 1.
    if_pend = 1'b1; if_addr = 32'h8;
    step();
    check_eq("A_if_ready", s_if_rdy, 1);
    check_eq("A_mem_we", s_mem_we, 0);
    step();
    check_eq("A_if_rsp", s_if_rsp, 1);
    check_eq("A_if_rdata", s_if_rdata, 32'h00A0_0093);
    step();

    // Simultaneous IF and LS store: LS first, IF next IDLE cycle.
    if_pend = 1'b1; if_addr = 32'h4;
    ls_set(32'h100, 1'b1, 4'hF, 32'hDEAD_BEEF);
    step();
    check_eq("B_ls_ready", s_ls_rdy, 1);
    check_eq("B_if_ready", s_if_rdy, 0);
    check_eq("B_mem_we", s_mem_we, 1);
    check_eq("B_mem_addr", s_mem_addr, 32'h100);
    step();
    check_eq("B_ls_rsp", s_ls_rsp, 1);
    check_eq("B_if_rsp_early", s_if_rsp, 0);
    step();
    check_eq("B_if_ready2", s_if_rdy, 1);
    check_eq("B_mem_addr2", s_mem_addr, 32'h4);
    step();
    check_eq("B_if_rsp", s_if_rsp, 1);
    ls_set(32'h100, 1'b1, 4'h3, 32'h1111_2222);
    repeat (2) step();
    ls_set(32'h100, 1'b0, 4'h0, 32'h0);
    repeat (2) step();
    check_eq("B_ls_rdata_merge", s_ls_rdata, 32'hDEAD_2222);
    step();

    // Starvation: LS always requesting; IF must win on its 3rd IDLE cycle, twice in a row.
    for (int r = 0; r < 2; r++) begin
      n_idle = 0; got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
        if (!if_pend) begin if_pend = 1'b1; if_addr = 32'h20 + 32'(r * 4); end
        if (!ls_pend) ls_set(32'h200 + 32'(i * 4), 1'b0, 4'h0, 32'h0);
        step();
        if (s_mem_v) n_idle++;
        if (s_if_rdy) got = 1'b1;
      end
      check_eq("C_if_granted", got, 1);
      check_eq("C_idle_cycles", n_idle, 3);
    end
    repeat (6) step();

    // Memory not ready for 5 cycles.
    rdy_mode = 2;
    ls_set(32'h44, 1'b0, 4'h0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("D_ls_ready_low", s_ls_rdy, 0);
      check_eq("D_mem_addr", s_mem_addr, 32'h44);
    end
    rdy_mode = 1;
    step();
    check_eq("D_ls_ready", s_ls_rdy, 1);
    step();
    check_eq("D_ls_rsp", s_ls_rsp, 1);
    check_eq("D_ls_rdata", s_ls_rdata, mem_rd(32'h44));
    step();

    // Reset while BUSY_LS; the late response must be dropped.
    lat_fix = 3;
    ls_set(32'h80, 1'b0, 4'h0, 32'h0);
    step();
    check_eq("E_ls_ready", s_ls_rdy, 1);
    reset = 1'b0;
    if_pend = 1'b1; if_addr = 32'h10;
    step();
    check_eq("E_rst_mem_valid", s_mem_v, 0);
    check_eq("E_rst_if_ready", s_if_rdy, 0);
    reset = 1'b1;
    lat_fix = 1;
    got = 1'b0; saw_ls = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      step();
      if (s_ls_rsp) saw_ls = 1'b1;
      if (s_if_rdy) got = 1'b1;
    end
    check_eq("E_no_ls_rsp", saw_ls, 0);
    check_eq("E_if_grant", got, 1);
    check_eq("E_if_addr", s_mem_addr, 32'h10);
    step();
    check_eq("E_if_rsp", s_if_rsp, 1);
    check_eq("E_if_rdata", s_if_rdata, mem_rd(32'h10));

    // Randomized traffic with random ready, latency and stray responses.
    rand_en = 1'b1; lat_fix = 0; rdy_mode = 0; stray_en = 1'b1;
    if_pct = 50; ls_pct = 50; repeat (600) step();
    if_pct = 30; ls_pct = 90; repeat (600) step();
    if_pct = 90; ls_pct = 20; repeat (600) step();
    rand_en = 1'b0; stray_en = 1'b0;
    repeat (30) step();
    check_eq("drain_if_q", q_if.size(), 0);
    check_eq("drain_ls_q", q_ls.size(), 0);

`ifdef MEM_ARBITER_PERF_EN
    check_eq("perf_if_grants", perf_if_grants, n_if_hs);
    check_eq("perf_ls_grants", perf_ls_grants, n_ls_hs);
    check_eq("perf_if_stall", perf_if_stall, n_if_stall);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one unified memory port between the core's instruction-fetch requester (IF) and its load/store requester (LS).
- Holds at most one transaction in flight and routes the response back to the requester that owns it.
- Default priority is LS over IF. A starvation guard forces an IF grant once fetch has waited too long.
- Sits between core_top's fetch/LSU logic and the memory model, replacing the split i_mem/d_mem paths so a multi-cycle core can stall on memory latency.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width; must be a multiple of 8.
- MAX_WAIT, 4, IF-waiting cycles after which IF overrides LS priority; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- if_req_valid  in  1  fetch request.
- if_req_ready  out  1  fetch request accepted this cycle.
- if_addr  in  ADDR_W  fetch address.
- if_rsp_valid  out  1  fetch data valid.
- if_rdata  out  DATA_W  fetch data.
- ls_req_valid  in  1  load/store request.
- ls_req_ready  out  1  load/store request accepted this cycle.
- ls_addr  in  ADDR_W  load/store address.
- ls_we  in  1  1 = store.
- ls_wstrb  in  DATA_W/8  byte enables for a store.
- ls_wdata  in  DATA_W  store data.
- ls_rsp_valid  out  1  load data valid, or store acknowledge.
- ls_rdata  out  DATA_W  load data.
- mem_req_valid  out  1  request to memory.
- mem_req_ready  in  1  memory accepts the request.
- mem_addr  out  ADDR_W  memory address.
- mem_we  out  1  memory write enable.
- mem_wstrb  out  DATA_W/8  memory byte enables.
- mem_wdata  out  DATA_W  memory write data.
- mem_rsp_valid  in  1  memory response, one cycle per transaction.
- mem_rdata  in  DATA_W  memory read data.

Behaviour:
- Handshake:
  - Requesters hold valid and all request fields stable until ready is seen.
  - A request transfers on valid && ready at a rising clk edge.
  - Memory completes each accepted request with exactly one mem_rsp_valid pulse, at least 1 cycle after acceptance.
- FSM states: IDLE, BUSY_IF, BUSY_LS.
- IDLE:
  - Winner is IF if the starvation flag is set and if_req_valid is high; otherwise LS if ls_req_valid; otherwise IF if if_req_valid.
  - mem_req_valid = winner exists. mem_* fields are a combinational mux of the winner's fields.
  - For IF grants: mem_we = 0, mem_wstrb = 0, mem_wdata = 0.
  - The winner's req_ready = mem_req_ready; the loser's req_ready = 0.
  - On handshake, go to BUSY_IF or BUSY_LS.
- BUSY_x:
  - mem_req_valid = 0; both req_ready = 0.
  - On mem_rsp_valid: x_rsp_valid = 1 in the same cycle (combinational pass-through), x_rdata = mem_rdata, next state IDLE.
  - Zero arbiter-added latency. Minimum issue interval is 2 cycles per transaction.
- Non-owning rsp_valid is always 0. if_rdata and ls_rdata may be driven from mem_rdata at all times; consumers qualify them with rsp_valid.
- Store acknowledge: ls_rsp_valid pulses; ls_rdata is don't-care.
- Starvation counter:
  - 4-bit register, reset 0.
  - Increments (saturating at MAX_WAIT) in every cycle where if_req_valid = 1 and no IF handshake occurs.
  - Clears on IF handshake.
  - Clears when if_req_valid = 0 in IDLE.
  - Flag = (count == MAX_WAIT).
- Simultaneous requests, flag clear: LS wins. IF wins next IDLE cycle if LS is not requesting again.
- mem_req_ready low in IDLE: stay in IDLE. The winner is re-evaluated every cycle, because valid is held and the flag may rise.
- mem_rsp_valid in IDLE is a protocol error: ignored, no rsp pulse to either requester.
- Reset (async, reset == 0):
  - state = IDLE, counter = 0.
  - All outputs 0: ready, rsp_valid, mem_req_valid, mem_we, mem_wstrb.
  - An in-flight response arriving after reset deassertion is dropped per the IDLE rule.

Optional Feature:
- Macro: MEM_ARBITER_PERF_EN.
- Defined: adds three output ports, each 32-bit, reset 0, wrapping at 2^32:
  - perf_if_grants: +1 per IF handshake.
  - perf_ls_grants: +1 per LS handshake.
  - perf_if_stall: +1 per cycle with if_req_valid && !if_req_ready.
- Undefined: the ports and counters are absent; the behaviour above is unchanged.

Decomposition:
- Package mem_arb_pkg contains:
  - arb_state_t enum {IDLE, BUSY_IF, BUSY_LS}.
  - arb_owner_t enum {OWN_IF, OWN_LS}.
  - STARVE_CNT_W = 4.
- Sub-module arb_starve_ctr: the saturating wait counter.
  - Inputs: waiting, grant, clear.
  - Output: flag.
  - Parameter: MAX_WAIT.

Test Plan:
- Reset during BUSY_LS (reset low 1 cycle), then mem_rsp_valid → all outputs 0 while reset is low; no ls_rsp_valid pulse; next IF request at 0x10 granted normally.
- IF-only read, addr 0x0000_0008, memory latency 1, rdata 0x00A0_0093 → if_req_ready pulse; if_rsp_valid 1 cycle later with 0x00A0_0093; mem_we = 0.
- Simultaneous IF (0x04) and LS store (0x100, wdata 0xDEAD_BEEF, wstrb 0xF), flag clear → LS granted first with mem_we = 1 and mem_addr 0x100; IF granted in the following IDLE cycle; ls_rsp_valid precedes if_rsp_valid.
- LS requests every IDLE cycle, IF held valid, MAX_WAIT = 4, latency 1 → IF granted no later than its 3rd IDLE cycle (counter reaches 4); counter returns to 0 after the grant.
- mem_req_ready held 0 for 5 cycles with LS valid → no handshake; state stays IDLE; ls_req_ready 0; mem_addr stable at ls_addr; transaction completes once ready rises.
- With MEM_ARBITER_PERF_EN: 3 IF and 2 LS transactions → perf_if_grants = 3, perf_ls_grants = 2, perf_if_stall equals the counted IF wait cycles.
